vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; next generation of the fixed 640x480 counter pair.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_sync_delay.sv | 34 +++
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types: per-axis porch/sync description, stock 640x480 constants,
// and a helper that totals an axis.
package vga_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
  } vga_axis_t;

  localparam vga_axis_t VGA_640X480_H = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48};
  localparam vga_axis_t VGA_640X480_V = '{h_active: 480, h_fp: 10, h_sync: 2, h_bp: 33};

  function automatic int axis_total(input vga_axis_t a);
    return a.h_active + a.h_fp + a.h_sync + a.h_bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enable gated shift register for the sync/blank bundle; DEPTH stages of delay,
// DEPTH=0 is a straight wire. Reset parks every stage at RST_VAL.
module vga_sync_delay #(
  parameter int              WIDTH   = 3,
  parameter int              DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset_n, ce};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with a frame-synchronous movable viewport.
// fetch_* is one register behind the counters; VGA_* trail fetch_* by PIPE_DLY pixels.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_640X480_H.h_active,
  parameter int H_FP      = VGA_640X480_H.h_fp,
  parameter int H_SYNC    = VGA_640X480_H.h_sync,
  parameter int H_BP      = VGA_640X480_H.h_bp,
  parameter int V_ACTIVE  = VGA_640X480_V.h_active,
  parameter int V_FP      = VGA_640X480_V.h_fp,
  parameter int V_SYNC    = VGA_640X480_V.h_sync,
  parameter int V_BP      = VGA_640X480_V.h_bp,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int VP_W      = 480,
  parameter int VP_H      = 400,
  parameter int VP_X0_RST = 80,
  parameter int VP_Y0_RST = 0,
  parameter int PIPE_DLY  = 2,
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [HW-1:0] vp_x0,
  input  logic [VW-1:0] vp_y0,
  input  logic          vp_load,
  output logic          pix_ce,
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y,
  output logic          fetch_valid,
  output logic          frame_start,
  output logic          line_start,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_n,
  output logic          VGA_SYNC_n
);

  localparam vga_axis_t H_AXIS = '{h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP};
  localparam vga_axis_t V_AXIS = '{h_active: V_ACTIVE, h_fp: V_FP, h_sync: V_SYNC, h_bp: V_BP};
  localparam int HT = axis_total(H_AXIS);
  localparam int VT = axis_total(V_AXIS);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST    = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] VP_W_L    = HW'(VP_W);
  localparam logic [VW-1:0] V_LAST    = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VP_H_L    = VW'(VP_H);
  localparam logic [2:0]    SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic [DW-1:0] div, div_nxt;
  logic          vga_clk_q;
  logic [HW-1:0] hcnt, org_x, pend_x;
  logic [VW-1:0] vcnt, org_y, pend_y;
  logic          h_wrap, v_wrap, frame_end;
  logic [HW:0]   dx;
  logic [VW:0]   dy;
  logic          in_x, in_y, in_vp;
  logic          hs_raw, vs_raw, blank_n_raw;
  logic [2:0]    sync_q, sync_out;

  // Pixel-rate divider; VGA_CLK is high for the upper half of each pixel period.
  assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  assign pix_ce  = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div       <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div       <= div_nxt;
      vga_clk_q <= (div_nxt >= DIV_HALF);
    end
  end

  assign h_wrap    = (hcnt == H_LAST);
  assign v_wrap    = (vcnt == V_LAST);
  assign frame_end = pix_ce && h_wrap && v_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_ce) begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
    end
  end

  // A load in the frame's last pixel clock lands in pending only; origin takes the old pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_x <= HW'(VP_X0_RST);
      pend_y <= VW'(VP_Y0_RST);
      org_x  <= HW'(VP_X0_RST);
      org_y  <= VW'(VP_Y0_RST);
    end else begin
      if (vp_load) begin
        pend_x <= vp_x0;
        pend_y <= vp_y0;
      end
      if (frame_end) begin
        org_x <= pend_x;
        org_y <= pend_y;
      end
    end
  end

  assign blank_n_raw = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign hs_raw      = (hcnt >= HS_BEG && hcnt < HS_END) ? HS_POL : ~HS_POL;
  assign vs_raw      = (vcnt >= VS_BEG && vcnt < VS_END) ? VS_POL : ~VS_POL;

  // One extra bit so a raster position left/above the origin shows up as negative.
  assign dx    = {1'b0, hcnt} - {1'b0, org_x};
  assign dy    = {1'b0, vcnt} - {1'b0, org_y};
  assign in_x  = !dx[HW] && (dx[HW-1:0] < VP_W_L);
  assign in_y  = !dy[VW] && (dy[VW-1:0] < VP_H_L);
  assign in_vp = in_x && in_y && blank_n_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_x     <= '0;
      fetch_y     <= '0;
      fetch_valid <= 1'b0;
      sync_q      <= SYNC_IDLE;
    end else if (pix_ce) begin
      fetch_x     <= in_vp ? dx[HW-1:0] : '0;
      fetch_y     <= in_vp ? dy[VW-1:0] : '0;
      fetch_valid <= in_vp;
      sync_q      <= {hs_raw, vs_raw, blank_n_raw};
    end
  end

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (pix_ce),
    .d       (sync_q),
    .q       (sync_out)
  );

  assign {VGA_HS, VGA_VS, VGA_BLANK_n} = sync_out;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_SYNC_n  = 1'b0;
  assign frame_start = pix_ce && (hcnt == '0) && (vcnt == '0);
  assign line_start  = pix_ce && (hcnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Small-raster bench: every clock is compared against a closed-form model indexed by clocks since reset.
module tb_vga_timing_gen;

  localparam int HA = 12, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int CD = 4, PD = 3;
  localparam int VPW = 6, VPH = 5, X0R = 3, Y0R = 1;
  localparam bit HSP = 1'b1, VSP = 1'b0;
  localparam int HW = $clog2(HT), VW = $clog2(VT);
  localparam int MAXF = 64;
  localparam int RST_AT = (12 * FT + 5 * HT + 7) * CD + 1;
  localparam int TOTAL = 30000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [HW-1:0] vp_x0;
  logic [VW-1:0] vp_y0;
  logic          vp_load;
  logic          pix_ce, fetch_valid, frame_start, line_start;
  logic [HW-1:0] fetch_x;
  logic [VW-1:0] fetch_y;
  logic          VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CLK_DIV(CD),
    .VP_W(VPW), .VP_H(VPH), .VP_X0_RST(X0R), .VP_Y0_RST(Y0R),
    .PIPE_DLY(PD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vp_x0(vp_x0), .vp_y0(vp_y0), .vp_load(vp_load),
    .pix_ce(pix_ce), .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
    .frame_start(frame_start), .line_start(line_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  always #5 clk = ~clk;

  int n_cmp, n_bad;
  int k;
  int pend_x, pend_y;
  int org_x [MAXF];
  int org_y [MAXF];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  // Expected fetch and pin values for global pixel index q counted from reset release.
  function automatic void pixel_ref(input int q, output int fx, output int fy, output int fv,
                                    output int hs, output int vs, output int bl);
    int f, h, v, dx, dy;
    f  = q / FT;
    h  = q % HT;
    v  = (q / HT) % VT;
    bl = (h < HA && v < VA) ? 1 : 0;
    hs = (h >= HA + HFP && h < HA + HFP + HSY) ? int'(HSP) : int'(!HSP);
    vs = (v >= VA + VFP && v < VA + VFP + VSY) ? int'(VSP) : int'(!VSP);
    dx = h - org_x[f];
    dy = v - org_y[f];
    fv = (bl == 1 && dx >= 0 && dx < VPW && dy >= 0 && dy < VPH) ? 1 : 0;
    fx = (fv == 1) ? dx : 0;
    fy = (fv == 1) ? dy : 0;
  endfunction

  task automatic reset_model();
    k = 0;
    pend_x = X0R;
    pend_y = Y0R;
    for (int f = 0; f < MAXF; f++) begin
      org_x[f] = X0R;
      org_y[f] = Y0R;
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_pix_ce", 32'(pix_ce), 0);
    check_eq("rst_fetch_x", 32'(fetch_x), 0);
    check_eq("rst_fetch_y", 32'(fetch_y), 0);
    check_eq("rst_fetch_valid", 32'(fetch_valid), 0);
    check_eq("rst_frame_start", 32'(frame_start), 0);
    check_eq("rst_line_start", 32'(line_start), 0);
    check_eq("rst_VGA_HS", 32'(VGA_HS), 32'(!HSP));
    check_eq("rst_VGA_VS", 32'(VGA_VS), 32'(!VSP));
    check_eq("rst_VGA_BLANK_n", 32'(VGA_BLANK_n), 0);
    check_eq("rst_VGA_CLK", 32'(VGA_CLK), 0);
    check_eq("rst_VGA_SYNC_n", 32'(VGA_SYNC_n), 0);
  endtask

  task automatic check_cycle();
    int ce, p, fx, fy, fv, hs, vs, bl, e_fs, e_ls, e_clk;
    ce    = (k % CD == CD - 1) ? 1 : 0;
    p     = k / CD;
    e_fs  = (ce == 1 && p % FT == 0) ? 1 : 0;
    e_ls  = (ce == 1 && p % HT == 0) ? 1 : 0;
    e_clk = ((k % CD) >= CD / 2) ? 1 : 0;
    check_eq("pix_ce", 32'(pix_ce), ce);
    check_eq("frame_start", 32'(frame_start), e_fs);
    check_eq("line_start", 32'(line_start), e_ls);
    check_eq("VGA_CLK", 32'(VGA_CLK), e_clk);
    check_eq("VGA_SYNC_n", 32'(VGA_SYNC_n), 0);
    if (p >= 1) pixel_ref(p - 1, fx, fy, fv, hs, vs, bl);
    else begin fx = 0; fy = 0; fv = 0; end
    check_eq("fetch_x", 32'(fetch_x), fx);
    check_eq("fetch_y", 32'(fetch_y), fy);
    check_eq("fetch_valid", 32'(fetch_valid), fv);
    if (p - 1 - PD >= 0) pixel_ref(p - 1 - PD, fx, fy, fv, hs, vs, bl);
    else begin hs = int'(!HSP); vs = int'(!VSP); bl = 0; end
    check_eq("VGA_HS", 32'(VGA_HS), hs);
    check_eq("VGA_VS", 32'(VGA_VS), vs);
    check_eq("VGA_BLANK_n", 32'(VGA_BLANK_n), bl);
  endtask

  // Origins switch only across a frame boundary; a load in that very clock waits a frame.
  task automatic model_edge();
    int p;
    p = k / CD;
    if (k % CD == CD - 1 && p % FT == FT - 1) begin
      org_x[p / FT + 1] = pend_x;
      org_y[p / FT + 1] = pend_y;
    end
    if (vp_load) begin
      pend_x = int'(vp_x0);
      pend_y = int'(vp_y0);
    end
  endtask

  task automatic drive_inputs();
    int p, fr, pos;
    p   = k / CD;
    fr  = p / FT;
    pos = p % FT;
    vp_x0   = HW'($urandom_range(0, HT + 4));
    vp_y0   = VW'($urandom_range(0, (1 << VW) - 1));
    vp_load = ($urandom_range(0, 299) == 0);
    if (fr == 2 && pos == 4 * HT + 5 && k % CD == 0) begin
      vp_x0 = HW'(7); vp_y0 = VW'(2); vp_load = 1'b1;
    end
    if ((fr == 5 || fr == 9) && pos == FT - 1 && k % CD == CD - 1) begin
      vp_x0 = HW'(0); vp_y0 = VW'(0); vp_load = 1'b1;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    k       = 0;
    reset_n = 1'b0;
    vp_load = 1'b0;
    vp_x0   = '0;
    vp_y0   = '0;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals();
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_model();
    for (int tot = 0; tot < TOTAL; tot++) begin
      if (tot == RST_AT) begin
        reset_n = 1'b0;
        vp_load = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_reset_vals();
          @(posedge clk);
          #1;
        end
        reset_n = 1'b1;
        reset_model();
      end
      drive_inputs();
      @(negedge clk);
      check_cycle();
      model_edge();
      @(posedge clk);
      #1;
      k++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
